// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// instruction classes, datapath mux selects and condition-code evaluation.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // nzcv is {N,Z,C,V}; the reserved code 1111 never executes.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = ~(n ^ v);
      COND_LT: res = n ^ v;
      COND_GT: res = ~z & ~(n ^ v);
      COND_LE: res = z | (n ^ v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// Architectural NZCV flags plus the per-instruction condition latch that gates
// every write of the instruction after DECODE.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_latch_cond,
  input  logic [1:0] i_flag_w,
  output logic       o_cond_q
);

  logic [1:0] r_nz;
  logic [1:0] r_cv;
  logic       r_cond_q;

  // Flag updates are gated by the instruction's own latched condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nz     <= 2'b00;
      r_cv     <= 2'b00;
      r_cond_q <= 1'b0;
    end else begin
      if (i_latch_cond) r_cond_q <= cond_holds(i_cond, {r_nz, r_cv});
      if (i_flag_w[1] && r_cond_q) r_nz <= i_alu_flags[3:2];
      if (i_flag_w[0] && r_cond_q) r_cv <= i_alu_flags[1:0];
    end
  end

  assign o_cond_q = r_cond_q;

endmodule

// File: rtl/multicycle_controller.sv
// Moore main FSM and ALU decoder sequencing the shared datapath; condition
// gating of PC/register/memory writes uses the latched cond from cond_unit.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [3:0]  state_dbg
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic       w_unused_rn;
  logic       w_next_pc, w_reg_w, w_mem_w, w_branch, w_alu_op;
  logic       w_no_write, w_pcs, w_cond_q;
  logic [1:0] w_flag_w;

  assign w_cond      = Instr[19:16];
  assign w_op        = Instr[15:14];
  assign w_funct     = Instr[13:8];
  assign w_rd        = Instr[3:0];
  assign w_unused_rn = ^Instr[7:4];

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state and raw per-state controls.
  always_comb begin
    w_next    = S_FETCH;
    w_next_pc = 1'b0;
    w_reg_w   = 1'b0;
    w_mem_w   = 1'b0;
    w_branch  = 1'b0;
    w_alu_op  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_next    = S_DECODE;
        IRWrite   = 1'b1;
        w_next_pc = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (w_op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DP:   w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_next  = w_funct[0] ? S_MEMRD : S_MEMWR;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        w_next = S_MEMWB;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        w_reg_w   = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        w_mem_w = 1'b1;
      end
      S_EXECUTER: begin
        w_next   = S_ALUWB;
        w_alu_op = 1'b1;
      end
      S_EXECUTEI: begin
        w_next   = S_ALUWB;
        ALUSrcB  = SRCB_IMM;
        w_alu_op = 1'b1;
      end
      S_ALUWB: w_reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        w_branch  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // ALU decoder: only EXECUTE states decode Funct; everything else adds.
  always_comb begin
    ALUControl = ALU_ADD;
    w_flag_w   = 2'b00;
    if (w_alu_op) begin
      case (w_funct[4:1])
        4'b0100: begin ALUControl = ALU_ADD; w_flag_w = {w_funct[0], w_funct[0]}; end
        4'b0010: begin ALUControl = ALU_SUB; w_flag_w = {w_funct[0], w_funct[0]}; end
        4'b1010: begin ALUControl = ALU_SUB; w_flag_w = {w_funct[0], w_funct[0]}; end
        4'b0000: begin ALUControl = ALU_AND; w_flag_w = {w_funct[0], 1'b0}; end
        4'b1100: begin ALUControl = ALU_ORR; w_flag_w = {w_funct[0], 1'b0}; end
        default: begin ALUControl = ALU_ADD; w_flag_w = 2'b00; end
      endcase
    end else begin
      ALUControl = ALU_ADD;
      w_flag_w   = 2'b00;
    end
  end

  // CMP suppression is decoded from Funct alone so it still holds in ALUWB.
  assign w_no_write = (w_op == OP_DP) && (w_funct[4:1] == 4'b1010);
  assign w_pcs      = ((w_rd == 4'hF) & w_reg_w) | w_branch;

  cond_unit u_cond (
    .clk          (clk),
    .rst_n        (reset),
    .i_cond       (w_cond),
    .i_alu_flags  (ALUFlags),
    .i_latch_cond (r_state == S_DECODE),
    .i_flag_w     (w_flag_w),
    .o_cond_q     (w_cond_q)
  );

  assign PCWrite   = w_next_pc | (w_pcs & w_cond_q);
  assign RegWrite  = w_reg_w & w_cond_q & ~w_no_write;
  assign MemWrite  = w_mem_w & w_cond_q;
  assign ImmSrc    = w_op;
  assign RegSrc    = {w_op == OP_MEM, w_op == OP_BR};
  assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed vector table, reset-mid-instruction sequence
// and random instructions checked cycle by cycle against a behavioural model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] Instr = 20'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  state_dbg;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .RegWrite(RegWrite), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4;
  localparam int MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9;

  typedef struct packed {
    logic nextpc, adr, irw, srca;
    logic [1:0] srcb, res;
    logic aluop, regw, memw, branch;
  } raw_t;

  typedef struct packed {
    logic [19:0] ins;
    logic [3:0]  af;
    logic [3:0]  lat;
    logic        regw, memw, pcw;
  } vec_t;

  raw_t       raw_tbl [10];
  vec_t       vecs [12];
  int         n_pass = 0, n_chk = 0;
  int         ms;
  logic [3:0] mflags;
  logic       mcondq;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0: return z;          4'd1: return !z;
      4'd2: return cy;         4'd3: return !cy;
      4'd4: return n;          4'd5: return !n;
      4'd6: return v;          4'd7: return !v;
      4'd8: return cy && !z;   4'd9: return !cy || z;
      4'd10: return n == v;    4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int next_of(input int st, input logic [19:0] ins);
    logic [1:0] op;
    op = ins[15:14];
    if (st == FETCH) return DECODE;
    if (st == DECODE) begin
      if (op == 2'd1) return MEMADR;
      if (op == 2'd0) return ins[13] ? EXECI : EXECR;
      if (op == 2'd2) return BRANCH;
      return FETCH;
    end
    if (st == MEMADR) return ins[8] ? MEMRD : MEMWR;
    if (st == MEMRD) return MEMWB;
    if (st == EXECR || st == EXECI) return ALUWB;
    return FETCH;
  endfunction

  function automatic int latency(input logic [19:0] ins);
    case (ins[15:14])
      2'd0: return 4;
      2'd1: return ins[8] ? 5 : 4;
      2'd2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [15:0] exp_out(input int st, input logic [19:0] ins, input logic cq);
    raw_t r;
    logic [1:0] op, aluc;
    logic [3:0] cmd;
    logic nowr, pcw;
    r = raw_tbl[st];
    op = ins[15:14];
    cmd = ins[12:9];
    aluc = 2'd0;
    if (r.aluop) begin
      if (cmd == 4'b0010 || cmd == 4'b1010) aluc = 2'd1;
      else if (cmd == 4'b0000) aluc = 2'd2;
      else if (cmd == 4'b1100) aluc = 2'd3;
    end
    nowr = (op == 2'd0) && (cmd == 4'b1010);
    pcw = r.nextpc | ((((ins[3:0] == 4'hF) & r.regw) | r.branch) & cq);
    return {pcw, r.adr, r.memw & cq, r.irw, r.res, r.srca, r.srcb, aluc, op,
            op == 2'b01, op == 2'b10, r.regw & cq & !nowr};
  endfunction

  // Model update for one clock edge, using the state before the edge.
  task automatic model_step(input logic [19:0] ins, input logic [3:0] af);
    logic [3:0] cmd;
    logic s, known, arith;
    cmd = ins[12:9];
    s = ins[8];
    known = cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    arith = cmd inside {4'b0100, 4'b0010, 4'b1010};
    if ((ms == EXECR || ms == EXECI) && mcondq) begin
      if (s && known) mflags[3:2] = af[3:2];
      if (s && arith) mflags[1:0] = af[1:0];
    end
    if (ms == DECODE) mcondq = cond_ok(ins[19:16], mflags);
    ms = next_of(ms, ins);
  endtask

  task automatic run_instr(input logic [19:0] ins, input logic [3:0] af, output int lat,
                           output logic regw_any, output logic memw_any, output logic pcw_late);
    int cyc;
    Instr = ins;
    ALUFlags = af;
    cyc = 0;
    regw_any = 1'b0;
    memw_any = 1'b0;
    pcw_late = 1'b0;
    do begin
      @(negedge clk);
      chk($sformatf("state(ins=%h,cyc=%0d)", ins, cyc), {28'd0, state_dbg}, ms);
      chk($sformatf("ctrl(ins=%h,st=%0d)", ins, ms),
          {16'd0, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite}, {16'd0, exp_out(ms, ins, mcondq)});
      if (cyc > 0) begin
        regw_any |= RegWrite;
        memw_any |= MemWrite;
        pcw_late |= PCWrite;
      end
      @(posedge clk);
      #1;
      model_step(ins, af);
      cyc++;
    end while (state_dbg != 4'd0 && cyc < 16);
    lat = cyc;
    ms = FETCH;
  endtask

  initial begin
    int lat;
    logic rw, mw, pw;
    logic [19:0] ins;
    raw_tbl[FETCH]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    raw_tbl[DECODE] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    raw_tbl[MEMADR] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    raw_tbl[MEMRD]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    raw_tbl[MEMWB]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    raw_tbl[MEMWR]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    raw_tbl[EXECR]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    raw_tbl[EXECI]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    raw_tbl[ALUWB]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
    raw_tbl[BRANCH] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};

    // {instr, ALUFlags, latency, any RegWrite, any MemWrite, PCWrite after FETCH}
    vecs[0]  = '{20'hE5910, 4'h0, 4'd5, 1'b1, 1'b0, 1'b0};  // LDR
    vecs[1]  = '{20'hE0501, 4'h4, 4'd4, 1'b1, 1'b0, 1'b0};  // SUBS -> Z
    vecs[2]  = '{20'h0A000, 4'h0, 4'd3, 1'b0, 1'b0, 1'b1};  // BEQ taken
    vecs[3]  = '{20'hE0902, 4'h0, 4'd4, 1'b1, 1'b0, 1'b0};  // ADDS -> clear
    vecs[4]  = '{20'h0A000, 4'h0, 4'd3, 1'b0, 1'b0, 1'b0};  // BEQ not taken
    vecs[5]  = '{20'hE1500, 4'h8, 4'd4, 1'b0, 1'b0, 1'b0};  // CMP -> N
    vecs[6]  = '{20'h4A000, 4'h0, 4'd3, 1'b0, 1'b0, 1'b1};  // BMI taken
    vecs[7]  = '{20'hF5800, 4'h0, 4'd4, 1'b0, 1'b0, 1'b0};  // STR never
    vecs[8]  = '{20'hE5800, 4'h0, 4'd4, 1'b0, 1'b1, 1'b0};  // STR
    vecs[9]  = '{20'hEC000, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0};  // Op=11
    vecs[10] = '{20'hE080F, 4'h0, 4'd4, 1'b1, 1'b0, 1'b1};  // ADD to PC
    vecs[11] = '{20'hE3803, 4'h0, 4'd4, 1'b1, 1'b0, 1'b0};  // ORR imm

    ms = FETCH;
    mflags = 4'h0;
    mcondq = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_state", {28'd0, state_dbg}, 32'd0);
    chk("por_irwrite", {31'd0, IRWrite}, 32'd1);
    chk("por_pcwrite", {31'd0, PCWrite}, 32'd1);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i].ins, vecs[i].af, lat, rw, mw, pw);
      chk($sformatf("vec%0d_latency", i), lat, {28'd0, vecs[i].lat});
      chk($sformatf("vec%0d_regwrite", i), {31'd0, rw}, {31'd0, vecs[i].regw});
      chk($sformatf("vec%0d_memwrite", i), {31'd0, mw}, {31'd0, vecs[i].memw});
      chk($sformatf("vec%0d_pcwrite", i), {31'd0, pw}, {31'd0, vecs[i].pcw});
    end

    // Reset asserted in MEMRD of an LDR, released before the next edge.
    Instr = 20'hE5910;
    ALUFlags = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_memrd", {28'd0, state_dbg}, 32'd3);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_state", {28'd0, state_dbg}, 32'd0);
    chk("async_reset_irwrite", {31'd0, IRWrite}, 32'd1);
    chk("async_reset_pcwrite", {31'd0, PCWrite}, 32'd1);
    chk("async_reset_adrsrc", {31'd0, AdrSrc}, 32'd0);
    chk("async_reset_regwrite", {31'd0, RegWrite}, 32'd0);
    @(negedge clk);
    chk("reset_held_state", {28'd0, state_dbg}, 32'd0);
    Instr = 20'hEC000;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_decode", {28'd0, state_dbg}, 32'd1);
    @(posedge clk);
    #1;
    chk("post_reset_fetch", {28'd0, state_dbg}, 32'd0);
    ms = FETCH;
    mflags = 4'h0;
    mcondq = 1'b1;
    run_instr(20'h4A000, 4'h0, lat, rw, mw, pw);
    chk("bmi_after_reset_flags_clear", {31'd0, pw}, 32'd0);

    for (int k = 0; k < 300; k++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 7) == 0) ins[3:0] = 4'hF;
      run_instr(ins, 4'($urandom), lat, rw, mw, pw);
      chk($sformatf("rand%0d_latency(ins=%h)", k, ins), lat, latency(ins));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit that sequences the shared 32-bit ARM-subset datapath over multiple cycles, with one ALU and one unified memory port. It is a Moore main FSM plus an ALU decoder and conditional-execution logic holding the architectural NZCV flags. It replaces the single-cycle decoder once the datapath is split into fetch/decode/execute/memory/writeback steps.

Parameters:
none (fixed ISA encoding)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = in reset)
Instr  in  20  IR bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  1  0=register A, 1=PC
ALUSrcB  out  2  00=register B, 01=ExtImm, 10=constant 4
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ImmSrc  out  2  = Op
RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
RegWrite  out  1  register file write enable
state_dbg  out  4  current state encoding

Behaviour:
- States (encoding 0..9): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions: FETCH->DECODE. DECODE: Op=01->MEMADR; Op=00,Funct[5]=0->EXECUTER; Op=00,Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH (treated as NOP). MEMADR: Funct[0]=1->MEMRD, else MEMWR. MEMRD->MEMWB->FETCH. MEMWR->FETCH. EXECUTER/EXECUTEI->ALUWB->FETCH. BRANCH->FETCH.
- Latency (cycles): LDR 5, STR 4, data-processing 4, B 3, Op=11 2.
- Per-state raw controls; all unlisted raw controls are 0:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decoder:
  - ALUOp=0 -> ADD, no flag write.
  - ALUOp=1 decodes Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB with NoWrite=1). Any other value -> ADD, no flags.
  - FlagW[1] (NZ) = Funct[0]. FlagW[0] (CV) = Funct[0] & (ADD|SUB|CMP).
- PCS = (Rd==4'hF & RegW) | Branch.
- Condition check:
  - Cond uses the registered flags: 0000 EQ, 0001 NE, 0010 CS, 0011 CC, 0100 MI, 0101 PL, 0110 VS, 0111 VC, 1000 HI, 1001 LS, 1010 GE, 1011 LT, 1100 GT, 1101 LE, 1110 AL. 1111 evaluates false.
  - CondEx is latched into cond_q at the end of the DECODE cycle. All later states of the instruction use cond_q, so a flag update in EXECUTE does not alter its own instruction's gating.
- Gated outputs:
  - PCWrite = NextPC | (PCS & cond_q).
  - RegWrite = RegW & cond_q & ~NoWrite.
  - MemWrite = MemW & cond_q.
  - NZ register loads ALUFlags[3:2] at the rising edge ending an EXECUTE state when FlagW[1] & cond_q. CV loads ALUFlags[1:0] likewise with FlagW[0].
- Reset: while reset=0, state=FETCH and flags=0000 and cond_q=0, taking effect immediately (asynchronous). Outputs decode FETCH combinationally. Reset asserted mid-instruction abandons it with no further writes. First post-reset edge moves to DECODE.
- Every output is a combinational function of state, Instr and registered flags/cond_q; none depends on ALUFlags except through the registers.

Decomposition:
- Package ctrl_pkg holds the state enum, the Op encodings (DP=00, MEM=01, BR=10), the ALUControl encodings, the condition-code constants and the ResultSrc/ALUSrcB encodings.
- One sub-module, cond_unit: NZ/CV flag registers, the condition evaluator and the cond_q latch. FSM and decoders stay in the top module.

Test Plan:
- Reset low mid-MEMRD, then high -> state_dbg=0 immediately; IRWrite=1, PCWrite=1; flags=0000. Next edge -> DECODE.
- LDR, Instr[31:12]=0xE591_0 (AL, Op=01, Funct=011001) -> states 0,1,2,3,4,0. RegWrite=1 only in MEMWB with ResultSrc=01; AdrSrc=1 in MEMRD.
- SUBS then BEQ: SUBS Funct=000101 with ALUFlags=0100 -> Z set after EXECUTER. Next BEQ (Cond=0000, Op=10) -> BRANCH with PCWrite=1, 3 cycles.
- Same BEQ with Z=0 -> BRANCH with PCWrite=0, RegWrite=0.
- CMP (Funct=010101) -> ALUControl=01 in EXECUTER; RegWrite=0 in ALUWB; flags updated.
- STR with Cond=1111 -> states 0,1,2,5,0 with MemWrite=0 throughout.
